// File: rtl/spi_slave_dp.sv
// spi_slave_dp: mode-0 SPI slave datapath with oversampled bus pins, one-deep TX buffer and held RX word.
module spi_slave_dp #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_load,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  input  logic             rx_ack,
  output logic             done,
  output logic             overrun,
  input  logic             ovr_clr
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [2:0] sclk_s;
  logic [1:0] ss_s, mosi_s;
  logic [CW-1:0] bitcnt;
  logic [WIDTH-1:0] tx_buf, tx_sr, rx_sr, tx_next;
  logic wrapped, start, abort, rise_sh, fall_sh, last, consume;
  always_comb begin
    start    = (state == IDLE) && !ss_s[1];
    abort    = (state == SHIFT) && ss_s[1];
    rise_sh  = (state == SHIFT) && !ss_s[1] && sclk_s[1] && !sclk_s[2];
    fall_sh  = (state == SHIFT) && !ss_s[1] && !sclk_s[1] && sclk_s[2];
    last     = rise_sh && (bitcnt == CW'(WIDTH - 1));
    consume  = start || (fall_sh && (bitcnt == '0) && wrapped);
    tx_next  = tx_ready ? '0 : tx_buf;
    state_nx = start ? SHIFT : abort ? IDLE : state;
  end
  assign miso_oe = (state == SHIFT);
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_s   <= '0;
      ss_s     <= '1;
      mosi_s   <= '0;
      miso     <= 1'b0;
      tx_ready <= 1'b1;
      tx_buf   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      bitcnt   <= '0;
      wrapped  <= 1'b0;
    end else begin
      sclk_s   <= {sclk_s[1:0], sclk};
      ss_s     <= {ss_s[0], ss_n};
      mosi_s   <= {mosi_s[0], mosi};
      done     <= last;
      tx_ready <= tx_load ? 1'b0 : consume ? 1'b1 : tx_ready;
      rx_valid <= last ? 1'b1 : rx_ack ? 1'b0 : rx_valid;
      overrun  <= (last && rx_valid && !rx_ack) ? 1'b1 : ovr_clr ? 1'b0 : overrun;
      if (tx_load) tx_buf <= tx_data;
      if (start) bitcnt <= '0;
      // a consume always sees the pre-load buffer, so a same-cycle tx_load is kept for the next word
      if (consume) begin
        tx_sr   <= tx_next;
        miso    <= tx_next[WIDTH-1];
        wrapped <= 1'b0;
      end else if (fall_sh && bitcnt != '0) begin
        tx_sr <= tx_sr << 1;
        miso  <= tx_sr[WIDTH-2];
      end
      if (rise_sh) begin
        rx_sr  <= {rx_sr[WIDTH-2:0], mosi_s[1]};
        bitcnt <= last ? '0 : bitcnt + 1'b1;
        if (last) begin
          rx_data <= {rx_sr[WIDTH-2:0], mosi_s[1]};
          wrapped <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_spi_slave_dp.sv
// tb_spi_slave_dp: drives a mode-0 SPI master at clk/8 and checks the slave against a word-level model.
module tb_spi_slave_dp;
  logic clk = 0, rst = 0, sclk = 0, ss_n = 1, mosi = 0;
  logic tx_load = 0, rx_ack = 0, ovr_clr = 0;
  logic [15:0] tx_data = 0;
  logic miso, miso_oe, tx_ready, rx_valid, done, overrun;
  logic [15:0] rx_data;
  int cmp = 0, errs = 0, done_cnt = 0;
  logic [15:0] m_buf = 0, m_rx = 0;
  bit m_full = 0, m_rxv = 0, m_ovr = 0;

  spi_slave_dp #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .tx_data(tx_data), .tx_load(tx_load),
    .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .done(done), .overrun(overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (done === 1'b1) done_cnt++;

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_load(input logic [15:0] v);
    tx_data = v; tx_load = 1; @(negedge clk); tx_load = 0;
    m_buf = v; m_full = 1;
  endtask

  task automatic cpu_ack;
    rx_ack = 1; @(negedge clk); rx_ack = 0; m_rxv = 0;
  endtask

  task automatic cpu_clr;
    ovr_clr = 1; @(negedge clk); ovr_clr = 0; m_ovr = 0;
  endtask

  function automatic logic [15:0] m_take();
    m_take = m_full ? m_buf : 16'h0;
    m_full = 0;
  endfunction

  // Master: nbits clocked MSB first; 16-bit words use words[15:0], 32-bit transfers words[31:16] then [15:0].
  task automatic spi_xfer(input logic [31:0] words, input int nbits, input int load_bit,
                          input logic [15:0] load_val, input bit ack_last,
                          output logic [31:0] got, output logic [31:0] exp,
                          output bit oe_ok, output logic rdy_seen);
    logic [31:0] s;
    logic [15:0] v;
    s = (nbits > 16) ? words : {words[15:0], 16'h0};
    got = 0; exp = 0; oe_ok = 1;
    exp[31:16] = m_take();
    mosi = s[31]; ss_n = 0;
    clks(4);
    rdy_seen = tx_ready;
    for (int i = 0; i < nbits; i++) begin
      sclk = 1;
      got[31-i] = miso;
      if (miso_oe !== 1'b1) oe_ok = 0;
      if (i % 16 == 15) begin
        if (m_rxv && !(ack_last && i == nbits - 1)) m_ovr = 1;
        m_rxv = 1;
        m_rx = s[31-16*(i/16) -: 16];
      end
      if (ack_last && i == nbits - 1) begin
        clks(2); rx_ack = 1; clks(1); rx_ack = 0; clks(1);
      end else clks(4);
      sclk = 0;
      if (i + 1 < nbits) mosi = s[30-i]; else mosi = 0;
      if (i % 16 == 15) begin
        v = m_take();
        if (i == 15 && nbits > 16) exp[15:0] = v;
      end
      if (i == load_bit) begin
        cpu_load(load_val); clks(3);
      end else clks(4);
    end
    ss_n = 1;
    clks(3);
    exp &= ~(32'hFFFF_FFFF >> nbits);
  endtask

  task automatic test_reset;
    clks(1);
    if ({miso, miso_oe, tx_ready, rx_data, rx_valid, done, overrun} !== {1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_state got %h exp %h", {miso, miso_oe, tx_ready, rx_data, rx_valid, done, overrun},
               {1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0});
      errs++;
    end
    cmp++;
    rst = 1;
    clks(2);
  endtask

  task automatic test_single;
    logic [31:0] got, exp; bit oe; logic rdy; int d0;
    cpu_load(16'hA5C3);
    if (tx_ready !== 1'b0) begin $display("FAIL single_load_ready got %b exp 0", tx_ready); errs++; end
    cmp++;
    d0 = done_cnt;
    spi_xfer(32'h0000_1234, 16, -1, 16'h0, 0, got, exp, oe, rdy);
    if (got !== exp) begin $display("FAIL single_miso got %h exp %h", got, exp); errs++; end
    cmp++;
    if (rdy !== 1'b1 || !oe) begin $display("FAIL single_ready_oe got rdy=%b oe=%b exp 1 1", rdy, oe); errs++; end
    cmp++;
    if (rx_data !== m_rx || rx_valid !== m_rxv) begin
      $display("FAIL single_rx got %h/%b exp %h/%b", rx_data, rx_valid, m_rx, m_rxv); errs++;
    end
    cmp++;
    if (done_cnt - d0 != 1) begin $display("FAIL single_done got %0d exp 1", done_cnt - d0); errs++; end
    cmp++;
  endtask

  task automatic test_back_to_back;
    logic [31:0] got, exp; bit oe; logic rdy; int d0;
    cpu_ack;
    cpu_load(16'h00FF);
    d0 = done_cnt;
    spi_xfer(32'h0001_8000, 32, 8, 16'hFF00, 0, got, exp, oe, rdy);
    if (got !== exp || !oe) begin $display("FAIL b2b_miso got %h exp %h oe=%b", got, exp, oe); errs++; end
    cmp++;
    if (done_cnt - d0 != 2) begin $display("FAIL b2b_done got %0d exp 2", done_cnt - d0); errs++; end
    cmp++;
    if ({rx_data, rx_valid, overrun, tx_ready} !== {m_rx, m_rxv, m_ovr, !m_full}) begin
      $display("FAIL b2b_flags got %h exp %h", {rx_data, rx_valid, overrun, tx_ready}, {m_rx, m_rxv, m_ovr, !m_full}); errs++;
    end
    cmp++;
    cpu_clr;
    if (overrun !== 1'b0) begin $display("FAIL b2b_ovr_clr got %b exp 0", overrun); errs++; end
    cmp++;
  endtask

  task automatic test_ack_same;
    logic [31:0] got, exp, w; bit oe; logic rdy;
    cpu_ack;
    w = $urandom;
    spi_xfer(w, 32, -1, 16'h0, 1, got, exp, oe, rdy);
    if ({rx_data, rx_valid, overrun} !== {m_rx, m_rxv, m_ovr} || overrun !== 1'b0) begin
      $display("FAIL ack_same got %h exp %h", {rx_data, rx_valid, overrun}, {m_rx, m_rxv, m_ovr}); errs++;
    end
    cmp++;
  endtask

  task automatic test_abort;
    logic [31:0] got, exp; bit oe; logic rdy; int d0;
    cpu_ack;
    cpu_load(16'($urandom));
    d0 = done_cnt;
    spi_xfer(32'($urandom), 7, -1, 16'h0, 0, got, exp, oe, rdy);
    if (miso_oe !== 1'b0) begin $display("FAIL abort_oe got %b exp 0", miso_oe); errs++; end
    cmp++;
    if (done_cnt != d0 || rx_data !== m_rx || rx_valid !== m_rxv) begin
      $display("FAIL abort_rx got done=%0d rx=%h/%b exp done=0 rx=%h/%b", done_cnt - d0, rx_data, rx_valid, m_rx, m_rxv); errs++;
    end
    cmp++;
    if (got !== exp || tx_ready !== !m_full) begin
      $display("FAIL abort_tx got %h/%b exp %h/%b", got, tx_ready, exp, !m_full); errs++;
    end
    cmp++;
    clks(2);
    spi_xfer(32'h0000_BEEF, 16, -1, 16'h0, 0, got, exp, oe, rdy);
    if (rx_data !== 16'hBEEF || rx_valid !== 1'b1) begin
      $display("FAIL abort_next got %h/%b exp beef/1", rx_data, rx_valid); errs++;
    end
    cmp++;
  endtask

  task automatic test_underflow;
    logic [31:0] got, exp; bit oe; logic rdy;
    cpu_ack;
    spi_xfer(32'h0000_5555, 16, -1, 16'h0, 0, got, exp, oe, rdy);
    if (got !== exp || exp !== 32'h0) begin $display("FAIL underflow_miso got %h exp %h", got, exp); errs++; end
    cmp++;
    if (rx_data !== 16'h5555) begin $display("FAIL underflow_rx got %h exp 5555", rx_data); errs++; end
    cmp++;
  endtask

  task automatic test_random;
    logic [31:0] got, exp; bit oe; logic rdy; int d0, nb, lb; bit ack;
    for (int n = 0; n < 8; n++) begin
      if ($urandom_range(1) == 1) cpu_ack;
      if ($urandom_range(1) == 1) cpu_clr;
      if ($urandom_range(1) == 1) cpu_load(16'($urandom));
      nb = ($urandom_range(1) == 1) ? 32 : 16;
      lb = ($urandom_range(1) == 1) ? 8 : -1;
      ack = 1'($urandom_range(1));
      d0 = done_cnt;
      spi_xfer(32'($urandom), nb, lb, 16'($urandom), ack, got, exp, oe, rdy);
      if (got !== exp || !oe) begin $display("FAIL rand%0d_miso got %h exp %h oe=%b", n, got, exp, oe); errs++; end
      cmp++;
      if ({rx_data, rx_valid, overrun, tx_ready} !== {m_rx, m_rxv, m_ovr, !m_full} || done_cnt - d0 != nb / 16) begin
        $display("FAIL rand%0d_state got %h done=%0d exp %h done=%0d", n, {rx_data, rx_valid, overrun, tx_ready},
                 done_cnt - d0, {m_rx, m_rxv, m_ovr, !m_full}, nb / 16);
        errs++;
      end
      cmp++;
      clks(2);
    end
  endtask

  task automatic test_reset_mid;
    logic [31:0] got, exp; bit oe; logic rdy; int d0;
    ss_n = 0; mosi = 1;
    clks(3);
    cpu_load(16'hC0DE);
    for (int i = 0; i < 9; i++) begin
      sclk = 1; clks(4);
      sclk = 0; mosi = ~mosi; clks(4);
    end
    #3 rst = 0;
    #1;
    if ({miso, miso_oe, tx_ready, rx_data, rx_valid, done, overrun} !== {1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0}) begin
      $display("FAIL reset_mid got %h exp %h", {miso, miso_oe, tx_ready, rx_data, rx_valid, done, overrun},
               {1'b0, 1'b0, 1'b1, 16'h0, 1'b0, 1'b0, 1'b0});
      errs++;
    end
    cmp++;
    @(negedge clk);
    ss_n = 1; sclk = 0; mosi = 0;
    clks(2);
    rst = 1;
    m_full = 0; m_rx = 0; m_rxv = 0; m_ovr = 0;
    clks(4);
    d0 = done_cnt;
    spi_xfer(32'h0000_1357, 16, -1, 16'h0, 0, got, exp, oe, rdy);
    if (rx_data !== 16'h1357 || rx_valid !== 1'b1 || done_cnt - d0 != 1 || got !== exp) begin
      $display("FAIL reset_after got rx=%h/%b done=%0d miso=%h exp rx=1357/1 done=1 miso=%h",
               rx_data, rx_valid, done_cnt - d0, got, exp);
      errs++;
    end
    cmp++;
  endtask

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_ack_same;
    test_abort;
    test_underflow;
    test_random;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
